// File: rtl/bit_scan_show_p.sv
// bit_scan_show_p: latches a word and emits one bit per step as {index, 3'b000, bit}
//   clk, rst             : clock, synchronous active-high reset
//   load/data/start_idx/dir : latch word, clamped scan limit and direction; begin scan
//   step_key / auto_key  : manual step pulse / MANUAL<->AUTO toggle pulse
//   num, index, ones_cnt : last emitted bit, next index, 1-bits emitted since load
//   led, done            : one-hot state (IDLE,MANUAL,AUTO,DONE) and DONE flag
module bit_scan_show_p #(
   parameter int DATA_W   = 16,
   parameter int IDX_W    = 4,
   parameter int TICK_CNT = 50000,
   parameter int TIM_W    = 26,
   parameter int WRAP     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   input  logic [IDX_W-1:0]  start_idx,
   input  logic              dir,
   input  logic              step_key,
   input  logic              auto_key,
   output logic [IDX_W+3:0]  num,
   output logic [IDX_W-1:0]  index,
   output logic [IDX_W:0]    ones_cnt,
   output logic [3:0]        led,
   output logic              done
);
   localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(DATA_W - 1);
   localparam logic [TIM_W-1:0] TIM_END  = TIM_W'(TICK_CNT - 1);
   localparam logic [IDX_W:0]   ONES_MAX = '1;
   typedef enum logic [1:0] {IDLE, MANUAL, AUTO, DONE} state_t;
   state_t            state, state_n;
   logic [DATA_W-1:0] shadow, sh;
   logic [IDX_W-1:0]  lim, start_c, first_idx, last_idx;
   logic [TIM_W-1:0]  tim, tim_n;
   logic              dir_r, emit, bit_v, at_last;
   assign start_c   = (start_idx > MAX_IDX) ? MAX_IDX : start_idx;
   assign first_idx = dir_r ? '0 : lim;
   assign last_idx  = dir_r ? lim : '0;
   assign at_last   = (index == last_idx);
   // shift rather than index so narrow DATA_W never sees an over-wide select
   assign sh        = shadow >> index;
   assign bit_v     = sh[0];
   always_comb begin
      state_n = state;
      tim_n   = tim;
      emit    = 1'b0;
      if (load) begin
         state_n = MANUAL;
         tim_n   = '0;
      end else begin
         case (state)
            MANUAL: begin
               if (auto_key) begin
                  state_n = AUTO;
                  tim_n   = '0;
               end else emit = step_key;
            end
            AUTO: begin
               if (auto_key) begin
                  state_n = MANUAL;
                  tim_n   = '0;
               end else if (tim == TIM_END) begin
                  tim_n = '0;
                  emit  = 1'b1;
               end else tim_n = tim + TIM_W'(1);
            end
            default: ;
         endcase
         if (emit && at_last && WRAP == 0) state_n = DONE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tim   <= '0;
         led   <= 4'b0001;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         tim   <= tim_n;
         led   <= 4'b0001 << state_n;
         done  <= (state_n == DONE);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow   <= '0;
         lim      <= '0;
         dir_r    <= 1'b0;
         index    <= '0;
         ones_cnt <= '0;
         num      <= '0;
      end else if (load) begin
         shadow   <= data;
         lim      <= start_c;
         dir_r    <= dir;
         index    <= dir ? '0 : start_c;
         ones_cnt <= '0;
         num      <= '0;
      end else if (emit) begin
         num      <= {index, 3'b000, bit_v};
         ones_cnt <= (bit_v && ones_cnt != ONES_MAX) ? ones_cnt + (IDX_W+1)'(1) : ones_cnt;
         index    <= at_last ? ((WRAP != 0) ? first_idx : index)
                             : (dir_r ? index + IDX_W'(1) : index - IDX_W'(1));
      end
   end
endmodule

// File: tb/tb_bit_scan_show_p.sv
// tb_bit_scan_show_p: directed checks of the bit scanner (stop mode, 16-bit) and wrap mode (8-bit)
module tb_bit_scan_show_p;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0, dir = 1'b0, step_key = 1'b0, auto_key = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  start_idx = '0;
   logic [7:0]  num_a, num_b;
   logic [3:0]  index_a, index_b, led_a, led_b;
   logic [4:0]  ones_a, ones_b;
   logic        done_a, done_b;
   logic [15:0] pat;
   logic [7:0]  exp_num;
   int          tests = 0, fails = 0;
   always #5 clk = ~clk;
   bit_scan_show_p #(.DATA_W(16), .IDX_W(4), .TICK_CNT(4), .TIM_W(4), .WRAP(0)) dut_a (
      .clk(clk), .rst(rst), .load(load), .data(data), .start_idx(start_idx), .dir(dir),
      .step_key(step_key), .auto_key(auto_key), .num(num_a), .index(index_a),
      .ones_cnt(ones_a), .led(led_a), .done(done_a));
   bit_scan_show_p #(.DATA_W(8), .IDX_W(4), .TICK_CNT(4), .TIM_W(4), .WRAP(1)) dut_b (
      .clk(clk), .rst(rst), .load(load), .data(data[7:0]), .start_idx(start_idx), .dir(dir),
      .step_key(step_key), .auto_key(auto_key), .num(num_b), .index(index_b),
      .ones_cnt(ones_b), .led(led_b), .done(done_b));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_load(input logic [15:0] d, input logic [3:0] s, input logic dr);
      data = d; start_idx = s; dir = dr; load = 1'b1;
      tick();
      load = 1'b0;
   endtask
   task automatic step();
      step_key = 1'b1;
      tick();
      step_key = 1'b0;
   endtask
   task automatic toggle();
      auto_key = 1'b1;
      tick();
      auto_key = 1'b0;
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      check("rst_led", led_a, 4'b0001);
      check("rst_num", num_a, 0);
      check("rst_index", index_a, 0);
      check("rst_ones", ones_a, 0);
      check("rst_done", done_a, 0);
      // stop-mode manual scan, high to low
      pat = 16'hA5C3;
      do_load(pat, 4'd15, 1'b0);
      check("m_load_led", led_a, 4'b0010);
      check("m_load_index", index_a, 15);
      for (int k = 0; k < 16; k++) begin
         step();
         exp_num = {4'(15 - k), 3'b000, pat[15 - k]};
         check("m_num", num_a, exp_num);
      end
      check("m_ones", ones_a, 8);
      check("m_led_done", led_a, 4'b1000);
      check("m_done", done_a, 1);
      check("m_index_held", index_a, 0);
      step();
      check("m_after_num", num_a, 8'h01);
      check("m_after_ones", ones_a, 8);
      // auto scan, low to high
      do_load(16'h0005, 4'd3, 1'b1);
      check("a_load_done", done_a, 0);
      toggle();
      check("a_led", led_a, 4'b0100);
      exp_num = 8'h00;
      for (int k = 0; k < 4; k++) begin
         repeat (3) tick();
         check("a_hold", num_a, exp_num);
         tick();
         pat = 16'h0005;
         exp_num = {4'(k), 3'b000, pat[k]};
         check("a_num", num_a, exp_num);
      end
      check("a_led_done", led_a, 4'b1000);
      check("a_done", done_a, 1);
      check("a_ones", ones_a, 2);
      check("a_index", index_a, 3);
      // reset mid-auto
      do_load(16'hFFFF, 4'd15, 1'b0);
      toggle();
      repeat (5) tick();
      check("r_pre_num", num_a, 8'hF1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r_led", led_a, 4'b0001);
      check("r_num", num_a, 0);
      check("r_index", index_a, 0);
      check("r_ones", ones_a, 0);
      // toggle and step together: toggle wins
      do_load(16'hFFFF, 4'd15, 1'b0);
      auto_key = 1'b1; step_key = 1'b1;
      tick();
      auto_key = 1'b0; step_key = 1'b0;
      check("c_led", led_a, 4'b0100);
      check("c_num", num_a, 0);
      repeat (4) tick();
      check("c_emit_num", num_a, 8'hF1);
      check("c_emit_ones", ones_a, 1);
      check("c_emit_index", index_a, 14);
      // load during auto restarts in manual
      do_load(16'h0003, 4'd15, 1'b1);
      check("l_led", led_a, 4'b0010);
      check("l_index", index_a, 0);
      check("l_ones", ones_a, 0);
      check("l_num", num_a, 0);
      // toggle coinciding with tick: toggle wins, no emit
      toggle();
      repeat (3) tick();
      toggle();
      check("t_led", led_a, 4'b0010);
      check("t_num", num_a, 0);
      check("t_index", index_a, 0);
      // wrap mode, two-bit scan
      do_load(16'h0002, 4'd1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("w_num", num_b, (k % 2 == 0) ? 8'h11 : 8'h00);
      end
      check("w_ones", ones_b, 3);
      check("w_done", done_b, 0);
      check("w_led", led_b, 4'b0010);
      // start index clamped to DATA_W-1
      do_load(16'h0080, 4'd15, 1'b0);
      check("k_index", index_b, 7);
      step();
      check("k_num", num_b, 8'h71);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
